// File: rtl/code_detector_pkg.sv
// code_detector_pkg
// Shared types and constants for the door-lock code detector.
//   state_e    : FSM state encoding (3-bit)
//   FAIL_LIMIT : wrong attempts that trigger a lockout (lockout build only)
//   LOCK_LEN   : cycles during which Start is ignored after a lockout triggers
package code_detector_pkg;

  typedef enum logic [2:0] {
    ST_WAIT  = 3'd0,
    ST_START = 3'd1,
    ST_RED1  = 3'd2,
    ST_BLUE  = 3'd3,
    ST_GREEN = 3'd4,
    ST_RED2  = 3'd5
  } state_e;

  localparam logic [1:0] FAIL_LIMIT = 2'd3;
  localparam logic [4:0] LOCK_LEN   = 5'd16;

endpackage

// File: rtl/code_detector_decode.sv
// code_detector_decode
// Combinational button decoder. A color counts only when it is the sole
// color pressed; any color at all raises a_o.
//   red_i, green_i, blue_i : debounced color buttons
//   a_o : any color pressed
//   r_o : red only
//   g_o : green only
//   b_o : blue only
module code_detector_decode (
  input  logic red_i,
  input  logic green_i,
  input  logic blue_i,
  output logic a_o,
  output logic r_o,
  output logic g_o,
  output logic b_o
);

  assign a_o = red_i | green_i | blue_i;
  assign r_o = red_i & ~green_i & ~blue_i;
  assign g_o = green_i & ~red_i & ~blue_i;
  assign b_o = blue_i & ~red_i & ~green_i;

endmodule

// File: rtl/code_detector.sv
// code_detector
// Moore FSM that unlocks (U high for one cycle) after Start followed by the
// color sequence Red, Blue, Green, Red. Cycles with no color pressed hold
// the current state; a wrong or multi-color press drops back to WAIT.
// Ports:
//   Clk   : clock, rising edge
//   Rst   : asynchronous active-low reset
//   Start : start button (honoured only in WAIT)
//   Red, Green, Blue : color buttons
//   U     : unlock, registered, high only while in RED2
// Optional feature: define CODE_DETECTOR_LOCKOUT_EN to count wrong attempts
// and ignore Start for LOCK_LEN cycles after FAIL_LIMIT failures.
module code_detector
  import code_detector_pkg::*;
(
  input  logic Clk,
  input  logic Rst,
  input  logic Start,
  input  logic Red,
  input  logic Green,
  input  logic Blue,
  output logic U
);

  logic   a, r, g, b;
  state_e state_q, state_d;
  logic   u_q;
  logic   wrong_color;
  logic   lock_active;

  code_detector_decode u_decode (
    .red_i   (Red),
    .green_i (Green),
    .blue_i  (Blue),
    .a_o     (a),
    .r_o     (r),
    .g_o     (g),
    .b_o     (b)
  );

  // Next-state logic. wrong_color flags a drop to WAIT caused by a bad press.
  always_comb begin
    state_d     = state_q;
    wrong_color = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (Start && !lock_active) state_d = ST_START;
      end
      ST_START: begin
        if (r) state_d = ST_RED1;
        else if (a) begin
          state_d     = ST_WAIT;
          wrong_color = 1'b1;
        end
      end
      ST_RED1: begin
        if (b) state_d = ST_BLUE;
        else if (a) begin
          state_d     = ST_WAIT;
          wrong_color = 1'b1;
        end
      end
      ST_BLUE: begin
        if (g) state_d = ST_GREEN;
        else if (a) begin
          state_d     = ST_WAIT;
          wrong_color = 1'b1;
        end
      end
      ST_GREEN: begin
        if (r) state_d = ST_RED2;
        else if (a) begin
          state_d     = ST_WAIT;
          wrong_color = 1'b1;
        end
      end
      ST_RED2: state_d = ST_WAIT;
      default: state_d = ST_WAIT;
    endcase
  end

  // State register plus registered unlock output; u_q mirrors (state_q == RED2)
  // without any combinational path from the buttons to U.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_WAIT;
      u_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      u_q     <= (state_d == ST_RED2);
    end
  end

  assign U = u_q;

`ifdef CODE_DETECTOR_LOCKOUT_EN
  logic [1:0] fail_q;
  logic [4:0] lock_q;

  assign lock_active = (lock_q != 5'd0);

  // While locked the FSM sits in WAIT with Start masked, so no failure or
  // success can coincide with the countdown. The failure count is cleared on
  // the last countdown cycle so the next attempt starts fresh.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      fail_q <= 2'd0;
      lock_q <= 5'd0;
    end else if (lock_active) begin
      lock_q <= lock_q - 5'd1;
      if (lock_q == 5'd1) fail_q <= 2'd0;
    end else if (state_d == ST_RED2) begin
      fail_q <= 2'd0;
    end else if (wrong_color) begin
      if (fail_q == FAIL_LIMIT - 2'd1) begin
        fail_q <= FAIL_LIMIT;
        lock_q <= LOCK_LEN;
      end else begin
        fail_q <= fail_q + 2'd1;
      end
    end
  end
`else
  logic unused_wrong_color;
  assign lock_active        = 1'b0;
  assign unused_wrong_color = wrong_color;
`endif

endmodule

// File: tb/tb_code_detector.sv
module tb_code_detector;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic Start = 1'b0, Red = 1'b0, Green = 1'b0, Blue = 1'b0;
  logic U;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  code_detector dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Start (Start),
    .Red   (Red),
    .Green (Green),
    .Blue  (Blue),
    .U     (U)
  );

  // One vector: up to 8 steps, each a nibble {Start,Red,Green,Blue} packed
  // MSB-first; exp_u bit (7-i) is the expected U after step i.
  typedef struct {
    string       name;
    int          len;
    logic [31:0] stim;
    logic [7:0]  exp_u;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: U=%b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of buttons, then sample 1 time unit after the edge.
  task automatic step(input logic [3:0] srgb);
    {Start, Red, Green, Blue} = srgb;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    {Start, Red, Green, Blue} = 4'b0000;
    Rst = 1'b0;
    #2;
    Rst = 1'b1;
  endtask

  localparam logic [11:0] CODE = 12'b100_001_010_100;

  initial begin
    logic [3:0] nib;
    logic       exp;
    logic [2:0] c;
    logic       sweep_ok;

    vecs[0] = '{"basic_rbgr",        6, 32'h84124000, 8'b00001000};
    vecs[1] = '{"idle_hold",         8, 32'h84000124, 8'b00000001};
    vecs[2] = '{"multi_color",       6, 32'h84612400, 8'b00000000};
    vecs[3] = '{"start_midseq",      7, 32'h84812400, 8'b00000100};
    vecs[4] = '{"start_with_color",  6, 32'h84924000, 8'b00001000};
    vecs[5] = '{"no_start",          4, 32'h41240000, 8'b00000000};
    vecs[6] = '{"wrong_order",       5, 32'h84214000, 8'b00000000};
    vecs[7] = '{"wait_ignores_color",6, 32'hC4124000, 8'b00001000};
    vecs[8] = '{"retry_after_wrong", 8, 32'h84484124, 8'b00000001};

    // Reset state, checked before the first clock edge.
    #2;
    check("reset_u", U, 1'b0);
    Rst = 1'b1;
    #10;

    // Table-driven vectors.
    for (int v = 0; v < 9; v++) begin
      int e0;
      e0 = errors;
      do_reset();
      for (int i = 0; i < vecs[v].len; i++) begin
        nib = vecs[v].stim[31 - 4*i -: 4];
        exp = vecs[v].exp_u[7 - i];
        step(nib);
        check(vecs[v].name, U, exp);
      end
      $display("vector %-20s steps=%0d errors=%0d", vecs[v].name, vecs[v].len, errors - e0);
    end

    // Async reset in RED2: U must drop before the next edge.
    do_reset();
    step(4'h8); step(4'h4); step(4'h1); step(4'h2); step(4'h4);
    check("red2_u", U, 1'b1);
    #2 Rst = 1'b0;
    #1 check("async_rst_red2", U, 1'b0);
    #1 Rst = 1'b1;
    step(4'h0);
    check("after_rst_red2", U, 1'b0);
    $display("sequence async_reset_red2 done errors=%0d", errors);

    // Async reset in GREEN: the final Red without a new Start does nothing.
    do_reset();
    step(4'h8); step(4'h4); step(4'h1); step(4'h2);
    check("green_u", U, 1'b0);
    #2 Rst = 1'b0;
    #1 check("async_rst_green", U, 1'b0);
    #1 Rst = 1'b1;
    step(4'h4);
    check("green_rst_red", U, 1'b0);
    step(4'h0);
    check("green_rst_idle", U, 1'b0);
    $display("sequence async_reset_green done errors=%0d", errors);

    // Exhaustive sweep of all 4-step color vectors.
    sweep_ok = 1'b1;
    for (int v = 0; v < 4096; v++) begin
      logic [11:0] vec;
      int          e1;
      vec = 12'(v);
      e1  = errors;
      do_reset();
      step(4'h8);
      for (int k = 0; k < 4; k++) begin
        c = vec[11 - 3*k -: 3];
        step({1'b0, c});
        check("sweep_step", U, (k == 3) && (vec == CODE));
      end
      step(4'h0);
      check("sweep_after", U, 1'b0);
      if (errors != e1) begin
        sweep_ok = 1'b0;
        $display("sweep vector %03b_%03b_%03b_%03b errors=%0d",
                 vec[11:9], vec[8:6], vec[5:3], vec[2:0], errors - e1);
      end
    end
    $display("sequence exhaustive_sweep vectors=4096 clean=%b", sweep_ok);

`ifdef CODE_DETECTOR_LOCKOUT_EN
    // Three failures, then Start held for 16 cycles must be ignored:
    // a following R,B,G,R without acceptance stays locked.
    do_reset();
    for (int f = 0; f < 3; f++) begin
      step(4'h8); step(4'h4); step(4'h2);
    end
    for (int i = 0; i < 16; i++) step(4'h8);
    step(4'h4); step(4'h1); step(4'h2); step(4'h4);
    check("lockout_hold", U, 1'b0);
    $display("sequence lockout_hold done errors=%0d", errors);

    // Same three failures, wait out 16 cycles, Start on cycle 17 works.
    do_reset();
    for (int f = 0; f < 3; f++) begin
      step(4'h8); step(4'h4); step(4'h2);
    end
    for (int i = 0; i < 16; i++) step(4'h0);
    step(4'h8); step(4'h4); step(4'h1); step(4'h2); step(4'h4);
    check("lockout_release", U, 1'b1);
    $display("sequence lockout_release done errors=%0d", errors);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/code_detector.md
# code_detector

Door-lock code detector: a Moore FSM that watches one Start button and three color buttons (Red, Green, Blue) and asserts the unlock output `U` for one cycle when, after Start, the exact sequence Red → Blue → Green → Red is entered. It sits between debounced, clock-synchronous button inputs and the door actuator driver.

## Interface
Parameters:
- none (behaviour is fixed; optional feature via macro, see Configuration)

Ports:
- `Clk`  in  1  system clock, rising-edge active
- `Rst`  in  1  reset; one clock; reset is asynchronous and active-low
- `Start`  in  1  start-code button, level, sampled on `Clk` rise
- `Red`  in  1  red button, level
- `Green`  in  1  green button, level
- `Blue`  in  1  blue button, level
- `U`  out  1  unlock; high only in state RED2

## Operation
- Decoded button terms per cycle:
  - `a` = Red|Green|Blue (any color pressed)
  - `r` = Red&~Green&~Blue
  - `g` = Green&~Red&~Blue
  - `b` = Blue&~Red&~Green
- States: WAIT, START, RED1, BLUE, GREEN, RED2. Reset state is WAIT.
- WAIT: Start=1 → START, else stay. Color inputs are ignored.
- START: r → RED1; ~a → stay; a&~r → WAIT.
- RED1: b → BLUE; ~a → stay; a&~b → WAIT.
- BLUE: g → GREEN; ~a → stay; a&~g → WAIT.
- GREEN: r → RED2; ~a → stay; a&~r → WAIT.
- RED2: unconditional → WAIT.
- Multiple colors pressed simultaneously count as wrong (a&~x) → WAIT.
- `Start` is ignored in every state other than WAIT; it does not restart a sequence in progress.
- `U` = (state == RED2). It is decoded from the state register only, with no combinational path from inputs.

## Timing
- Reset: `U`=0 and state=WAIT immediately on `Rst` low, independent of `Clk`.
- One transition per rising edge. Inputs held for exactly one cycle each work, because of the "no color → stay" rule.
- Latency: with Start sampled at edge 0 and colors sampled at edges 1–4, `U` goes high after edge 4 and stays high for exactly one cycle. The FSM returns to WAIT at edge 5.
- Reset asserted mid-sequence: the sequence is abandoned and `U` drops at once.
- Reset is released synchronously by the integrator. The FSM takes no action on the release edge other than leaving reset.

## Configuration
- Macro `CODE_DETECTOR_LOCKOUT_EN`:
  - Defined: a 2-bit failure counter increments on every transition to WAIT caused by a wrong color. On reaching 3 failures, Start is ignored for 16 cycles (lockout counter). The lockout then clears and the failure count resets. A successful RED2 also clears the failure count. Both counters reset to 0.
  - Undefined: no counters; behaviour exactly as in Operation.

## Structure
- Package `code_detector_pkg`:
  - state enum (WAIT, START, RED1, BLUE, GREEN, RED2, 3-bit)
  - lockout constants (fail limit 3, lockout length 16)
- Sub-module `code_detector_decode`: combinational button decoder producing `a`, `r`, `g`, `b`.
- Top level holds the state register, next-state logic, output decode and optional lockout counters.

## Test plan
- Reset then Start=1, then one cycle each of R, B, G, R (RGB = 100, 001, 010, 100) → `U`=0 through the colors, `U`=1 for exactly one cycle after the 4th color, then 0 in WAIT.
- Exhaustive sweep of all 4096 four-step color vectors (each step 3 bits), with a reset and Start before each → `U`=1 only for 100,001,010,100; `U`=0 for every other vector and at every intermediate step.
- Start, R, then no color for 3 cycles, then B, G, R → `U`=1 (idle cycles hold state).
- Start, R, then R+G simultaneously → return to WAIT; a subsequent B, G, R without a new Start → `U` stays 0.
- Assert `Rst` low asynchronously in the GREEN state (between clock edges) → `U`=0 immediately; the next correct color without Start has no effect.
- With `CODE_DETECTOR_LOCKOUT_EN`: three wrong attempts → Start ignored for 16 cycles. A correct sequence started at cycle 17 → `U`=1.
